// File: rtl/fifo_if.sv
// fifo_if: producer/consumer handshake bundle for the byte FIFO
interface fifo_if #(parameter int WIDTH = 8);
  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] data_in;
  logic             full_flag;
  logic             empty_flag;
  logic [WIDTH-1:0] data_out;
  modport master (output w_en, r_en, data_in, input full_flag, empty_flag, data_out);
  modport slave  (input w_en, r_en, data_in, output full_flag, empty_flag, data_out);
endinterface

// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data and occupancy-decoded full/empty flags
module fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic   clk,
  input logic   rst_n,
  fifo_if.slave bus
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              wr_ok;
  logic              rd_ok;
  // Flags come from the registered count, so they move on the same edge as the transfer
  assign bus.full_flag  = count == (ADDR_W+1)'(DEPTH);
  assign bus.empty_flag = count == '0;
  assign wr_ok = bus.w_en && !bus.full_flag;
  assign rd_ok = bus.r_en && !bus.empty_flag;
  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr] <= bus.data_in;
  // Pointers wrap naturally at DEPTH (power of two); data_out holds unless a read is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.data_out <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr         <= rptr + 1'b1;
        bus.data_out <= mem[rptr];
      end
      count <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed scoreboard bench for the byte FIFO
module tb_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt = 0;
  logic [7:0] last = 8'h00;
  logic [7:0] sb [$];
  logic [7:0] fill_pat [8] = '{8'h99, 8'hE1, 8'h99, 8'hF0, 8'h99, 8'hE1, 8'h99, 8'hF0};

  fifo_if #(.WIDTH(8)) bus ();
  fifo #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " data_out"}, bus.data_out, last);
    chk({tag, " empty"}, {7'd0, bus.empty_flag}, {7'd0, cnt == 0});
    chk({tag, " full"}, {7'd0, bus.full_flag}, {7'd0, cnt == 8});
  endtask

  // One clock: drive requests, predict acceptance from the model count, then check after the edge
  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    wa = w && cnt != 8;
    ra = r && cnt != 0;
    bus.w_en = w;
    bus.r_en = r;
    bus.data_in = d;
    if (wa) sb.push_back(d);
    @(posedge clk);
    #1;
    if (ra) last = sb.pop_front();
    cnt = cnt + int'(wa) - int'(ra);
    check_state(tag);
  endtask

  initial begin
    bus.w_en = 1'b1;
    bus.r_en = 1'b0;
    bus.data_in = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;
    cyc("idle", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 1'b0, fill_pat[i]);
    cyc("overflow", 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 8; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
    cyc("underflow", 1'b0, 1'b1, 8'h00);
    chk("underflow hold", bus.data_out, 8'hF0);
    for (int i = 0; i < 5; i++) cyc("wrap wr", 1'b1, 1'b0, 8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) cyc("wrap rd", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) cyc("both", 1'b1, 1'b1, 8'h10 + 8'(i));
    chk("both count2", {6'd0, bus.full_flag, bus.empty_flag}, 8'h00);
    for (int i = 0; i < 2; i++) cyc("wrap drain", 1'b0, 1'b1, 8'h00);
    cyc("empty both", 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) cyc("pre rst", 1'b1, 1'b0, 8'h40 + 8'(i));
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    cnt = 0;
    last = 8'h00;
    check_state("async rst");
    #1 rst_n = 1'b1;
    cyc("post rst wr", 1'b1, 1'b0, 8'h77);
    cyc("post rst rd", 1'b0, 1'b1, 8'h00);
    chk("post rst data", bus.data_out, 8'h77);
    cyc("post rst empty rd", 1'b0, 1'b1, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
